// File: rtl/detect_burst_split_pkg.sv
// detect_burst_split_pkg: shared types and helpers for burst inference.
// Holds the FSM encoding, default widths and boundary math.
package detect_burst_split_pkg;

  localparam int ADDR_W         = 64;
  localparam int LEN_W          = 8;
  localparam int WAIT_W         = 4;
  localparam int NUM_LEN_OUT    = 2;
  localparam int BEAT_BYTES_LOG = 6;
  localparam int BOUNDARY_LOG   = 12;
  localparam int MAX_ADDR_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } burst_state_e;

  function automatic logic [LEN_W+ADDR_W-1:0] pack_burst(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

  // True when addr sits on the first byte of a boundary region.
  function automatic logic crosses_boundary(
    input logic [MAX_ADDR_W-1:0] addr,
    input int                    blog
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << blog) - MAX_ADDR_W'(1);
    return (addr & mask) == '0;
  endfunction

endpackage

// File: rtl/detect_burst_split_if.sv
// detect_burst_split_if: address-FIFO input and burst/len FIFO outputs.
// slave is the burst detector, master is the surrounding FIFO side.
interface detect_burst_split_if
  import detect_burst_split_pkg::*;
#(
  parameter int AddrWidth     = ADDR_W,
  parameter int BurstLenWidth = LEN_W,
  parameter int NumLenOutputs = NUM_LEN_OUT
);

  logic [AddrWidth-1:0]                   addr_dout;
  logic                                   addr_empty_n;
  logic                                   addr_read;
  logic [BurstLenWidth+AddrWidth-1:0]     addr_din;
  logic                                   addr_full_n;
  logic                                   addr_write;
  logic [NumLenOutputs*BurstLenWidth-1:0] burst_len_din;
  logic [NumLenOutputs-1:0]               burst_len_full_n;
  logic [NumLenOutputs-1:0]               burst_len_write;

  modport slave (
    input  addr_dout,
    input  addr_empty_n,
    output addr_read,
    output addr_din,
    input  addr_full_n,
    output addr_write,
    output burst_len_din,
    input  burst_len_full_n,
    output burst_len_write
  );

  modport master (
    output addr_dout,
    output addr_empty_n,
    input  addr_read,
    input  addr_din,
    output addr_full_n,
    input  addr_write,
    input  burst_len_din,
    output burst_len_full_n,
    input  burst_len_write
  );

endinterface

// File: rtl/detect_burst_split_fanout.sv
// burst_fanout: all-or-nothing push of one burst length
// to the address FIFO and every length consumer.
module burst_fanout
  import detect_burst_split_pkg::*;
#(
  parameter int LenWidth = LEN_W,
  parameter int NumOut   = NUM_LEN_OUT
) (
  input  logic                       en,
  input  logic [LenWidth-1:0]        len,
  input  logic                       addr_full_n,
  input  logic [NumOut-1:0]          len_full_n,
  output logic                       fire,
  output logic [NumOut*LenWidth-1:0] len_din,
  output logic [NumOut-1:0]          len_write
);

  assign fire      = en & addr_full_n & (&len_full_n);
  assign len_write = {NumOut{fire}};
  assign len_din   = {NumOut{len}};

endmodule

// File: rtl/detect_burst_split.sv
// detect_burst_split: coalesces word addresses into INCR bursts,
// closed by length cap, region boundary, idle timeout or flush.
module detect_burst_split
  import detect_burst_split_pkg::*;
#(
  parameter int AddrWidth         = ADDR_W,
  parameter int DataWidthBytesLog = BEAT_BYTES_LOG,
  parameter int WaitTimeWidth     = WAIT_W,
  parameter int BurstLenWidth     = LEN_W,
  parameter int NumLenOutputs     = NUM_LEN_OUT,
  parameter int BoundaryLog       = BOUNDARY_LOG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WaitTimeWidth-1:0] max_wait_time,
  input  logic [BurstLenWidth-1:0] max_burst_len,
  input  logic                     flush,
  output logic                     busy,
  detect_burst_split_if.slave      bus
);

  burst_state_e state_q, state_d;

  logic [AddrWidth-1:0]     base_q, base_d;
  logic [BurstLenWidth-1:0] len_q, len_d;
  logic [WaitTimeWidth-1:0] wait_q, wait_d;

  logic [AddrWidth-1:0] beats;
  logic [AddrWidth-1:0] next_addr;
  logic                 crosses;
  logic                 close_now;
  logic                 contig;
  logic                 emit_en;
  logic                 fire;
  logic                 pop;

  assign beats     = AddrWidth'(len_q) + AddrWidth'(1);
  assign next_addr = base_q + (beats << DataWidthBytesLog);
  assign crosses   = crosses_boundary(MAX_ADDR_W'(next_addr), BoundaryLog);
  assign close_now = (len_q >= max_burst_len) | crosses;
  assign contig    = bus.addr_dout == next_addr;
  assign emit_en   = state_q == EMIT;

  burst_fanout #(
    .LenWidth (BurstLenWidth),
    .NumOut   (NumLenOutputs)
  ) u_fanout (
    .en          (emit_en),
    .len         (len_q),
    .addr_full_n (bus.addr_full_n),
    .len_full_n  (bus.burst_len_full_n),
    .fire        (fire),
    .len_din     (bus.burst_len_din),
    .len_write   (bus.burst_len_write)
  );

  assign bus.addr_write = fire;
  assign bus.addr_read  = pop;

  if (BurstLenWidth == LEN_W && AddrWidth == ADDR_W) begin : g_pack
    assign bus.addr_din = pack_burst(len_q, base_q);
  end else begin : g_cat
    assign bus.addr_din = {len_q, base_q};
  end

  // State and burst registers; reset drops any open burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
    end
  end

  // Next state: grow, close or restart the burst in priority order.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (bus.addr_empty_n) begin
          base_d  = bus.addr_dout;
          len_d   = '0;
          wait_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (close_now) begin
          state_d = EMIT;
        end else if (bus.addr_empty_n && contig) begin
          len_d  = len_q + BurstLenWidth'(1);
          wait_d = '0;
        end else if (bus.addr_empty_n) begin
          state_d = EMIT;
        end else if (flush || wait_q >= max_wait_time) begin
          state_d = EMIT;
        end else if (wait_q != '1) begin
          wait_d = wait_q + WaitTimeWidth'(1);
        end
      end
      EMIT: begin
        if (fire) begin
          if (bus.addr_empty_n) begin
            base_d  = bus.addr_dout;
            len_d   = '0;
            wait_d  = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pop only words that start or extend a burst.
  always_comb begin
    pop  = 1'b0;
    busy = state_q != IDLE;
    unique case (state_q)
      IDLE:    pop = bus.addr_empty_n;
      ACCUM:   pop = bus.addr_empty_n & contig & ~close_now;
      EMIT:    pop = fire & bus.addr_empty_n;
      default: pop = 1'b0;
    endcase
    pop = pop & rst_n;
  end

endmodule

// File: tb/tb_detect_burst_split.sv
// tb_detect_burst_split: vector table, corner sequences and random
// streams checked against a list-level burst model.
module tb_detect_burst_split;

  typedef struct packed {
    logic [7:0]  len;
    logic [63:0] addr;
  } burst_t;

  typedef struct {
    logic [63:0] start;
    int          n;
    logic        has_x;
    logic [63:0] xaddr;
    int          mbl;
    int          nb;
    logic [7:0]  l0, l1, l2;
    logic [63:0] a0, a1, a2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] max_wait_time;
  logic [7:0] max_burst_len;
  logic       flush;
  logic       busy;

  detect_burst_split_if #(
    .AddrWidth     (64),
    .BurstLenWidth (8),
    .NumLenOutputs (2)
  ) bus ();

  detect_burst_split dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .max_wait_time (max_wait_time),
    .max_burst_len (max_burst_len),
    .flush         (flush),
    .busy          (busy),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap_cnt = 0;

  logic       rand_gaps = 1'b0;
  logic       rand_bp = 1'b0;
  logic       force_afull = 1'b1;
  logic [1:0] force_lfull = 2'b11;

  logic [63:0] src_q[$];
  logic [63:0] stim[$];
  burst_t      got_q[$];
  burst_t      exp_q[$];
  int          pop_cyc[$];
  int          fire_cyc[$];

  logic       aw_s;
  logic [1:0] blw_s;

  vec_t vecs[7];

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    pop_cyc.delete();
    fire_cyc.delete();
  endtask

  task automatic drive_src();
    if (gap_cnt > 0) begin
      bus.addr_empty_n = 1'b0;
      gap_cnt--;
    end else begin
      bus.addr_empty_n = src_q.size() > 0;
    end
    bus.addr_dout = (src_q.size() > 0) ? src_q[0] : 64'hDEAD_0000;
    if (rand_bp) begin
      bus.addr_full_n = $urandom_range(0, 3) != 0;
      bus.burst_len_full_n = {$urandom_range(0, 3) != 0,
                              $urandom_range(0, 3) != 0};
    end else begin
      bus.addr_full_n = force_afull;
      bus.burst_len_full_n = force_lfull;
    end
  endtask

  task automatic sample();
    logic ready;
    aw_s  = bus.addr_write;
    blw_s = bus.burst_len_write;
    ready = bus.addr_full_n & (&bus.burst_len_full_n);
    if (bus.addr_read) begin
      check("pop_when_empty", 128'(bus.addr_empty_n), 128'(1));
      pop_cyc.push_back(cyc);
    end
    if (bus.addr_write || (|bus.burst_len_write)) begin
      check("atomic_emit",
            128'({bus.addr_write, bus.burst_len_write, ready}),
            128'(4'hF));
      check("len_fanout", 128'(bus.burst_len_din),
            128'({2{bus.addr_din[71:64]}}));
      got_q.push_back(bus.addr_din);
      fire_cyc.push_back(cyc);
    end
  endtask

  task automatic step();
    logic popped;
    logic [63:0] dummy;
    @(negedge clk);
    popped = bus.addr_read;
    sample();
    @(posedge clk);
    #1;
    cyc++;
    if (popped && src_q.size() > 0) begin
      dummy = src_q.pop_front();
      if (rand_gaps) gap_cnt = $urandom_range(0, 3);
    end
    drive_src();
  endtask

  task automatic run_until(input int budget, input string name);
    int n;
    n = 0;
    drive_src();
    while ((src_q.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles",
               name, budget);
    end
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    while (pop_cyc.size() == 0 && n < 20) begin
      step();
      n++;
    end
    check({name, "_pop_seen"}, 128'(pop_cyc.size()), 128'(1));
  endtask

  // Bursts from an address list with no idle gaps: extend while
  // contiguous, under the cap and not entering a new 4 KB region.
  function automatic void build_model(input int mbl);
    int          i;
    int          len;
    logic [63:0] base;
    logic [63:0] nx;
    exp_q.delete();
    i = 0;
    while (i < stim.size()) begin
      base = stim[i];
      len = 0;
      i++;
      while (i < stim.size()) begin
        nx = base + 64'(len + 1) * 64;
        if (len >= mbl || nx % 4096 == 0 || stim[i] != nx) break;
        len++;
        i++;
      end
      exp_q.push_back('{8'(len), base});
    end
  endfunction

  function automatic int lat();
    if (fire_cyc.size() == 0 || pop_cyc.size() == 0) return -1;
    return fire_cyc[0] - pop_cyc[0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;

    vecs[0] = '{64'h1000, 8, 1'b0, 64'h0, 15, 1,
                8'd7, 8'd0, 8'd0, 64'h1000, 64'h0, 64'h0};
    vecs[1] = '{64'h0, 20, 1'b0, 64'h0, 15, 2,
                8'd15, 8'd3, 8'd0, 64'h0, 64'h400, 64'h0};
    vecs[2] = '{64'hF80, 4, 1'b0, 64'h0, 15, 2,
                8'd1, 8'd1, 8'd0, 64'hF80, 64'h1000, 64'h0};
    vecs[3] = '{64'h0, 2, 1'b1, 64'h200, 15, 2,
                8'd1, 8'd0, 8'd0, 64'h0, 64'h200, 64'h0};
    vecs[4] = '{64'h80, 3, 1'b0, 64'h0, 0, 3,
                8'd0, 8'd0, 8'd0, 64'h80, 64'hC0, 64'h100};
    vecs[5] = '{64'h2000, 6, 1'b0, 64'h0, 3, 2,
                8'd3, 8'd1, 8'd0, 64'h2000, 64'h2100, 64'h0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FF80, 3, 1'b0, 64'h0, 15, 2,
                8'd1, 8'd0, 8'd0, 64'hFFFF_FFFF_FFFF_FF80,
                64'h0, 64'h0};

    rst_n = 1'b0;
    flush = 1'b0;
    max_wait_time = 4'd3;
    max_burst_len = 8'd15;
    bus.addr_dout = 64'h40;
    bus.addr_empty_n = 1'b1;
    bus.addr_full_n = 1'b1;
    bus.burst_len_full_n = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_addr_read", 128'(bus.addr_read), 128'(0));
    check("reset_writes",
          128'({bus.addr_write, bus.burst_len_write}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_src();

    foreach (vecs[k]) begin
      clear_logs();
      stim.delete();
      for (int j = 0; j < vecs[k].n; j++)
        stim.push_back(vecs[k].start + 64'(j) * 64);
      if (vecs[k].has_x) stim.push_back(vecs[k].xaddr);
      max_burst_len = 8'(vecs[k].mbl);
      max_wait_time = 4'd3;
      foreach (stim[j]) src_q.push_back(stim[j]);
      run_until(500, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_nbursts", k),
            128'(got_q.size()), 128'(vecs[k].nb));
      check($sformatf("vec%0d_pops", k),
            128'(pop_cyc.size()), 128'(stim.size()));
      if (got_q.size() >= 1)
        check($sformatf("vec%0d_b0", k), 128'(got_q[0]),
              128'({vecs[k].l0, vecs[k].a0}));
      if (vecs[k].nb >= 2 && got_q.size() >= 2)
        check($sformatf("vec%0d_b1", k), 128'(got_q[1]),
              128'({vecs[k].l1, vecs[k].a1}));
      if (vecs[k].nb >= 3 && got_q.size() >= 3)
        check($sformatf("vec%0d_b2", k), 128'(got_q[2]),
              128'({vecs[k].l2, vecs[k].a2}));
      if (vecs[k].has_x && pop_cyc.size() == 3 && fire_cyc.size() > 0)
        check($sformatf("vec%0d_hold_noncontig", k),
              128'(pop_cyc[2] >= fire_cyc[0]), 128'(1));
    end

    // Lone-address latency for two wait settings.
    clear_logs();
    max_burst_len = 8'd15;
    max_wait_time = 4'd3;
    src_q.push_back(64'h5000);
    run_until(100, "lat3");
    check("latency_w3", 128'(lat()), 128'(5));

    clear_logs();
    max_wait_time = 4'd0;
    src_q.push_back(64'h5040);
    run_until(100, "lat0");
    check("latency_w0", 128'(lat()), 128'(2));

    // Flush two cycles after the pop beats a long timeout.
    clear_logs();
    max_wait_time = 4'd10;
    src_q.push_back(64'h6000);
    drive_src();
    wait_pop("flush");
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_until(100, "flush");
    check("flush_latency", 128'(lat()), 128'(3));
    if (got_q.size() > 0)
      check("flush_burst", 128'(got_q[0]), 128'({8'd0, 64'h6000}));

    // One len consumer stalled for five EMIT cycles.
    clear_logs();
    max_wait_time = 4'd0;
    force_lfull = 2'b01;
    src_q.push_back(64'h7000);
    drive_src();
    wait_pop("bp");
    step();
    for (int j = 0; j < 5; j++) begin
      step();
      check($sformatf("bp_addr_write_c%0d", j), 128'(aw_s), 128'(0));
      check($sformatf("bp_len0_write_c%0d", j),
            128'(blw_s[0]), 128'(0));
    end
    force_lfull = 2'b11;
    drive_src();
    step();
    check("bp_release_writes", 128'({aw_s, blw_s}), 128'(3'b111));
    run_until(50, "bp");
    check("bp_nbursts", 128'(got_q.size()), 128'(1));
    if (got_q.size() > 0)
      check("bp_burst", 128'(got_q[0]), 128'({8'd0, 64'h7000}));

    // Reset in the middle of an open burst discards it.
    clear_logs();
    max_wait_time = 4'd10;
    src_q.push_back(64'h8000);
    drive_src();
    wait_pop("rst");
    step();
    step();
    check("rst_pre_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_busy_now", 128'(busy), 128'(0));
    check("rst_no_write", 128'(bus.addr_write), 128'(0));
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("rst_no_burst", 128'(got_q.size()), 128'(0));

    // Random streams with short input gaps and random sink stalls.
    rand_gaps = 1'b1;
    rand_bp = 1'b1;
    max_wait_time = 4'd8;
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      stim.delete();
      a = 64'($urandom_range(0, 255)) * 64;
      for (int j = 0; j < 50; j++) begin
        stim.push_back(a);
        if ($urandom_range(0, 4) != 0) a = a + 64;
        else a = 64'($urandom_range(0, 255)) * 64;
      end
      max_burst_len = 8'($urandom_range(0, 15));
      build_model(int'(max_burst_len));
      foreach (stim[j]) src_q.push_back(stim[j]);
      run_until(3000, $sformatf("rand%0d", r));
      check($sformatf("rand%0d_nbursts", r),
            128'(got_q.size()), 128'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
        check($sformatf("rand%0d_b%0d", r, j),
              128'(got_q[j]), 128'(exp_q[j]));
    end
    rand_gaps = 1'b0;
    rand_bp = 1'b0;
    drive_src();
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
